sparc_instr_encoder: RTL and testbench

Pipelined SPARC V9 instruction encoder, the inverse of `decode_unit`: it accepts decoded fields over a valid/ready handshake and emits the packed 32-bit instruction word. It also flags immediates that do not fit their field. It sits on the stimulus side of the decoder fault-injection bench and turns field-level stimulus into raw words for the decoder under test. It also provides round-trip checking against decoder outputs.

---
 rtl/sparc_enc_pkg.sv | 48 ++++
 rtl/sparc_field_pack.sv | 45 ++++
 rtl/sparc_instr_encoder.sv | 88 ++++++++
 tb/tb_sparc_instr_encoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_enc_pkg.sv
// Shared types and constants for the SPARC V9 instruction encoder.
// Imported by the field packer and the pipelined top level.
package sparc_enc_pkg;

  typedef enum logic [1:0] {
    FMT_CALL  = 2'd0,
    FMT_BR    = 2'd1,
    FMT_ARITH = 2'd2,
    FMT_MEM   = 2'd3
  } fmt_e;

  localparam logic [1:0] OP_BR    = 2'b00;
  localparam logic [1:0] OP_CALL  = 2'b01;
  localparam logic [1:0] OP_ARITH = 2'b10;
  localparam logic [1:0] OP_MEM   = 2'b11;

  localparam logic [2:0] OP2_SETHI = 3'b100;

  localparam int unsigned CALL_DISP_W = 30;
  localparam int unsigned DISP22_W    = 22;
  localparam int unsigned SIMM13_W    = 13;

  typedef struct packed {
    fmt_e        fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  op2;
    logic [5:0]  op3;
    logic        i;
    logic [63:0] imm;
  } enc_bundle_t;

  // A value fits a signed field when everything above the field's sign bit
  // is a copy of that sign bit.
  function automatic logic fits_signed(input logic [63:0] v, input int unsigned bits);
    logic [63:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

  function automatic logic fits_unsigned(input logic [63:0] v, input int unsigned bits);
    logic [63:0] hi;
    hi = v >> bits;
    return hi == '0;
  endfunction

endpackage

// File: rtl/sparc_field_pack.sv
// Combinational packer: turns a decoded field bundle into a 32-bit SPARC V9
// word and flags immediates that were truncated to fit their field.
module sparc_field_pack
  import sparc_enc_pkg::*;
(
  input  enc_bundle_t bundle,
  output logic [31:0] word,
  output logic        fail
);

  logic [12:0] low13;

  assign low13 = bundle.i ? bundle.imm[12:0] : {8'h00, bundle.rs2};

  // NOTE: every output gets a default before the case so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    word = '0;
    fail = 1'b0;
    unique case (bundle.fmt)
      FMT_CALL: begin
        word = {OP_CALL, bundle.imm[29:0]};
        fail = !fits_signed(bundle.imm, CALL_DISP_W);
      end
      FMT_BR: begin
        word = {OP_BR, bundle.rd, bundle.op2, bundle.imm[21:0]};
        // SETHI loads the upper bits of a constant, so its field is unsigned.
        if (bundle.op2 == OP2_SETHI)
          fail = !fits_unsigned(bundle.imm, DISP22_W);
        else
          fail = !fits_signed(bundle.imm, DISP22_W);
      end
      FMT_ARITH, FMT_MEM: begin
        word = {(bundle.fmt == FMT_MEM) ? OP_MEM : OP_ARITH, bundle.rd, bundle.op3,
                bundle.rs1, bundle.i, low13};
        fail = bundle.i && !fits_signed(bundle.imm, SIMM13_W);
      end
      default: begin
        word = '0;
        fail = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sparc_instr_encoder.sv
// Two-stage pipelined SPARC V9 instruction encoder with valid/ready handshakes
// on both sides and saturating delivered/failed word counters.
module sparc_instr_encoder
  import sparc_enc_pkg::*;
(
  input  logic        rclk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_op2,
  input  logic [5:0]  in_op3,
  input  logic        in_i,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_fail,
  output logic [15:0] enc_count,
  output logic [15:0] fail_count
);

  enc_bundle_t in_bundle;
  enc_bundle_t s1_bundle;
  logic        s1_valid;
  logic        s2_valid;
  logic        adv1;
  logic        adv2;
  logic [31:0] pack_word;
  logic        pack_fail;
  logic        out_fire;

  assign in_bundle = '{fmt: fmt_e'(in_fmt), rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                       op2: in_op2, op3: in_op3, i: in_i, imm: in_imm};

  // A stage may load whenever the stage after it is empty or draining, so a
  // full pipe still moves one word per cycle; in_ready is combinational from
  // out_ready as a result.
  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;
  assign out_fire  = s2_valid && out_ready;

  sparc_field_pack u_pack (
    .bundle (s1_bundle),
    .word   (pack_word),
    .fail   (pack_fail)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge rclk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_bundle <= '0;
      s2_valid  <= 1'b0;
      out_instr <= '0;
      out_fail  <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) s1_bundle <= in_bundle;
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_instr <= pack_word;
          out_fail  <= pack_fail;
        end
      end
    end
  end

  always_ff @(posedge rclk or negedge reset_n) begin
    if (!reset_n) begin
      enc_count  <= '0;
      fail_count <= '0;
    end else if (out_fire) begin
      if (enc_count != 16'hFFFF) enc_count <= enc_count + 16'd1;
      if (out_fail && fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sparc_instr_encoder.sv
// Self-checking bench for sparc_instr_encoder: directed vectors, backpressure,
// mid-stream reset and a randomized run against a queue-based reference model.
module tb_sparc_instr_encoder;

  logic        rclk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_op2;
  logic [5:0]  in_op3;
  logic        in_i;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_fail;
  logic [15:0] enc_count;
  logic [15:0] fail_count;

  sparc_instr_encoder dut (
    .rclk       (rclk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_op2     (in_op2),
    .in_op3     (in_op3),
    .in_i       (in_i),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_fail   (out_fail),
    .enc_count  (enc_count),
    .fail_count (fail_count)
  );

  always #5 rclk = ~rclk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] exp_q[$];
  int          exp_enc  = 0;
  int          exp_fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference encoder: returns {fail, word}, built from field positions and
  // numeric range limits.
  function automatic logic [32:0] ref_enc(input logic [1:0] f, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [2:0] op2, input logic [5:0] op3,
                                          input logic i, input logic [63:0] imm);
    longint          s;
    longint unsigned w;
    longint unsigned low;
    bit              bad;
    s = imm;
    if (f == 2'd0) begin
      bad = (s < -(64'sd1 <<< 29)) || (s >= (64'sd1 <<< 29));
      w   = (64'd1 << 30) | (imm & ((64'd1 << 30) - 1));
    end else if (f == 2'd1) begin
      if (op2 == 3'd4) bad = imm >= (64'd1 << 22);
      else             bad = (s < -(64'sd1 <<< 21)) || (s >= (64'sd1 <<< 21));
      w = (64'(rd) << 25) | (64'(op2) << 22) | (imm & ((64'd1 << 22) - 1));
    end else begin
      bad = i && ((s < -4096) || (s > 4095));
      low = i ? (imm & 64'h1FFF) : 64'(rs2);
      w   = (64'(2 + f[0]) << 30) | (64'(rd) << 25) | (64'(op3) << 19) |
            (64'(rs1) << 14) | (64'(i) << 13) | low;
    end
    return {bad, w[31:0]};
  endfunction

  task automatic set_fields(input logic [1:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] op2, input logic [5:0] op3,
                            input logic i, input logic [63:0] imm);
    in_fmt = f; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_op2 = op2; in_op3 = op3; in_i = i; in_imm = imm;
  endtask

  task automatic rand_fields();
    longint v;
    int     k;
    set_fields(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               ($urandom % 3 == 0) ? 3'd4 : 3'($urandom), 6'($urandom), 1'($urandom), '0);
    case ($urandom % 4)
      0: in_imm = {$urandom, $urandom};
      1: in_imm = 64'(longint'($urandom_range(0, 20000)) - 10000);
      2: begin
        case ($urandom % 4)
          0: k = 12;
          1: k = 21;
          2: k = 22;
          default: k = 29;
        endcase
        v = longint'(1) <<< k;
        if ($urandom % 2) v = -v;
        v = v + longint'($urandom_range(0, 2)) - 1;
        in_imm = 64'(v);
      end
      default: in_imm = 64'($urandom_range(0, 5000000));
    endcase
  endtask

  // One clock cycle: entered and left at a falling edge with inputs already
  // driven; records transfers against the model and checks the counters.
  task automatic step(output bit acc);
    #1;
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(ref_enc(in_fmt, in_rd, in_rs1, in_rs2, in_op2, in_op3, in_i, in_imm));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 64'(out_valid), 64'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("word", 64'(out_instr), 64'(e[31:0]));
        check("fail", 64'(out_fail), 64'(e[32]));
        if (exp_enc < 65535) exp_enc++;
        if (e[32] && exp_fails < 65535) exp_fails++;
      end
    end
    @(posedge rclk);
    @(negedge rclk);
    check("enc_count", 64'(enc_count), 64'(exp_enc));
    check("fail_count", 64'(fail_count), 64'(exp_fails));
  endtask

  task automatic directed(input string tag, input logic [31:0] word, input logic fail);
    bit acc;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step(acc);
    check({tag, "_accept"}, 64'(acc), 64'd1);
    in_valid = 1'b0;
    check({tag, "_not_yet"}, 64'(out_valid), 64'd0);
    step(acc);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_instr"}, 64'(out_instr), 64'(word));
    check({tag, "_fail"}, 64'(out_fail), 64'(fail));
    step(acc);
  endtask

  task automatic do_reset();
    @(negedge rclk);
    reset_n = 1'b0;
    exp_q.delete();
    exp_enc   = 0;
    exp_fails = 0;
    @(negedge rclk);
    reset_n = 1'b1;
    @(negedge rclk);
  endtask

  initial begin
    bit acc;
    int idx;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_fields('0, '0, '0, '0, '0, '0, 1'b0, '0);
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_fail", 64'(out_fail), 64'd0);
    check("rst_enc_count", 64'(enc_count), 64'd0);
    check("rst_fail_count", 64'(fail_count), 64'd0);
    @(negedge rclk);
    reset_n = 1'b1;
    @(negedge rclk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    set_fields(2'd2, 5'd3, 5'd0, 5'd0, 3'd0, 6'h02, 1'b1, 64'd1);
    directed("f3_imm", 32'h86102001, 1'b0);
    set_fields(2'd2, 5'd0, 5'd12, 5'd8, 3'd0, 6'h11, 1'b0, 64'd0);
    directed("f3_reg", 32'h808B0008, 1'b0);
    set_fields(2'd1, 5'd2, 5'd0, 5'd0, 3'd4, 6'h00, 1'b0, 64'd6);
    directed("sethi", 32'h05000006, 1'b0);
    set_fields(2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 6'h00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    directed("call", 32'h7FFFFFFF, 1'b0);
    set_fields(2'd2, 5'd3, 5'd0, 5'd0, 3'd0, 6'h02, 1'b1, 64'd4096);
    directed("range_hi", 32'h86103000, 1'b1);
    check("range_fail_count", 64'(fail_count), 64'd1);
    set_fields(2'd2, 5'd3, 5'd0, 5'd0, 3'd0, 6'h02, 1'b1, -64'sd4096);
    directed("range_lo", 32'h86103000, 1'b0);

    // Backpressure: capacity two, then release and drain in order.
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      set_fields(2'd2, 5'(idx + 1), 5'd1, 5'd2, 3'd0, 6'h05, 1'b0, '0);
      step(acc);
      if (acc) idx++;
    end
    check("bp_accepts", 64'(idx), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("bp_consecutive", 64'(out_valid), 64'd1);
      if (idx < 3) set_fields(2'd2, 5'(idx + 1), 5'd1, 5'd2, 3'd0, 6'h05, 1'b0, '0);
      in_valid = (idx < 3);
      step(acc);
      if (acc) idx++;
    end
    check("bp_enc_count", 64'(enc_count), 64'd3);
    check("bp_drained", 64'(out_valid), 64'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_fields();
    step(acc);
    rand_fields();
    step(acc);
    in_valid = 1'b0;
    check("mid_full", 64'(in_ready), 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_out_valid", 64'(out_valid), 64'd0);
    check("mid_out_instr", 64'(out_instr), 64'd0);
    check("mid_out_fail", 64'(out_fail), 64'd0);
    check("mid_enc_count", 64'(enc_count), 64'd0);
    check("mid_fail_count", 64'(fail_count), 64'd0);
    exp_q.delete();
    exp_enc   = 0;
    exp_fails = 0;
    @(negedge rclk);
    reset_n = 1'b1;
    @(negedge rclk);
    check("mid_in_ready", 64'(in_ready), 64'd1);
    set_fields(2'd1, 5'd2, 5'd0, 5'd0, 3'd4, 6'h00, 1'b0, 64'd6);
    directed("post_reset", 32'h05000006, 1'b0);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      rand_fields();
      step(acc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) step(acc);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_out_valid", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
